// File: rtl/uart_audio_packetizer.sv
// uart_audio_packetizer: decimates and frames multi-channel audio samples,
// buffers whole frames and streams them out on an 8N1 UART line.
module uart_audio_packetizer #(
    parameter int         NUM_CH       = 4,
    parameter int         SAMPLE_W     = 24,
    parameter int         OUT_BYTES    = 2,
    parameter int         FIFO_DEPTH   = 4,
    parameter int         CLKS_PER_BIT = 109,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    localparam int        CSW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic [NUM_CH*SAMPLE_W-1:0] sample_in,
    input  logic                       sample_valid_in,
    input  logic                       enable_in,
    input  logic [1:0]                 mode_in,
    input  logic [CSW-1:0]             chan_sel_in,
    input  logic [3:0]                 decim_in,
    output logic                       tx_out,
    output logic                       busy_out,
    output logic                       overflow_out,
    output logic [15:0]                frame_count_out
);

    localparam int W   = OUT_BYTES * 8;
    localparam int CW  = $clog2(NUM_CH + 1);
    localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int BW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int WIW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BSW = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;

    typedef enum logic [1:0] {IDLE, SYNC, DATA} state_t;

    logic [1:0]            rst_sync;
    logic                  rst_n;
    logic [3:0]            dec_cnt;
    logic                  accept;
    logic [CSW-1:0]        sel;
    logic [NUM_CH*W-1:0]   new_words;
    logic [CW-1:0]         new_cnt;
    logic [NUM_CH*W-1:0]   fifo_words [FIFO_DEPTH];
    logic [CW-1:0]         fifo_cnt [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           level;
    logic                  empty;
    logic                  full;
    logic                  push;
    logic                  pop;
    state_t                state;
    state_t                state_nxt;
    logic [NUM_CH*W-1:0]   cur_words;
    logic [CW-1:0]         cur_cnt;
    logic [WIW-1:0]        word_idx;
    logic [BSW-1:0]        byte_sel;
    logic [WIW-1:0]        nx_word;
    logic [BSW-1:0]        nx_sel;
    logic [7:0]            nx_byte;
    logic [9:0]            shreg;
    logic [BW-1:0]         clk_cnt;
    logic [3:0]            bit_cnt;
    logic                  bit_end;
    logic                  byte_done;
    logic                  last_byte;
    logic                  unused_bits;

    assign unused_bits = ^sample_in;

    // Reset asserts asynchronously, releases on a clock edge.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) rst_sync <= '0;
        else           rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_n = rst_sync[1];

    assign accept = enable_in && sample_valid_in && (dec_cnt == 4'd0);

    // Decimation counter: cleared while disabled, wraps at decim_in.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            dec_cnt <= '0;
        end else if (!enable_in) begin
            dec_cnt <= '0;
        end else if (sample_valid_in) begin
            if (dec_cnt >= decim_in) dec_cnt <= '0;
            else                     dec_cnt <= dec_cnt + 4'd1;
        end
    end

    // Build the candidate frame from the current inputs.
    always_comb begin
        new_words = '0;
        new_cnt   = CW'(NUM_CH);
        sel       = '0;
        if (int'(chan_sel_in) < NUM_CH) sel = chan_sel_in;
        unique case (mode_in)
            2'd0: begin
                new_words[W-1:0] =
                    sample_in[int'(sel)*SAMPLE_W + SAMPLE_W - W +: W];
                new_cnt = CW'(1);
            end
            2'd2: begin
                for (int k = 0; k < NUM_CH; k++)
                    new_words[k*W +: W] = W'(int'(frame_count_out) + k);
            end
            default: begin
                for (int k = 0; k < NUM_CH; k++)
                    new_words[k*W +: W] =
                        sample_in[k*SAMPLE_W + SAMPLE_W - W +: W];
            end
        endcase
    end

    assign empty    = (level == '0);
    assign full     = (level == (AW+1)'(FIFO_DEPTH));
    assign push     = accept && (!full || pop);
    assign busy_out = !empty || (state != IDLE);

    // Frame storage; no reset needed, occupancy tracks validity.
    always_ff @(posedge clk_in) begin
        if (push) begin
            fifo_words[wr_ptr] <= new_words;
            fifo_cnt[wr_ptr]   <= new_cnt;
        end
    end

    // FIFO pointers, occupancy, drop flag and accepted-frame count.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            level           <= '0;
            overflow_out    <= 1'b0;
            frame_count_out <= '0;
        end else begin
            if (push) begin
                wr_ptr          <= wr_ptr + AW'(1);
                frame_count_out <= frame_count_out + 16'd1;
            end
            if (accept && !push) overflow_out <= 1'b1;
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    assign bit_end   = (clk_cnt == BW'(CLKS_PER_BIT - 1));
    assign byte_done = bit_end && (bit_cnt == 4'd9);
    assign last_byte = (int'(word_idx) == int'(cur_cnt) - 1) &&
                       (byte_sel == '0);

    // Serialiser state register.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Serialiser next state and FIFO pop.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = SYNC;
                end
            end
            SYNC: if (byte_done) state_nxt = DATA;
            DATA: if (byte_done && last_byte) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Index of the next data byte: MSB byte first within each word.
    always_comb begin
        nx_word = word_idx;
        nx_sel  = byte_sel;
        if (state == DATA) begin
            if (byte_sel == '0) begin
                nx_sel  = BSW'(OUT_BYTES - 1);
                nx_word = word_idx + WIW'(1);
            end else begin
                nx_sel = byte_sel - BSW'(1);
            end
        end
        nx_byte = cur_words[int'(nx_word)*W + int'(nx_sel)*8 +: 8];
    end

    // Bit timing and shift register; tx_out is the register LSB.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cur_words <= '0;
            cur_cnt   <= '0;
            word_idx  <= '0;
            byte_sel  <= '0;
            shreg     <= '1;
            clk_cnt   <= '0;
            bit_cnt   <= '0;
        end else if (pop) begin
            cur_words <= fifo_words[rd_ptr];
            cur_cnt   <= fifo_cnt[rd_ptr];
            word_idx  <= '0;
            byte_sel  <= BSW'(OUT_BYTES - 1);
            shreg     <= {1'b1, SYNC_BYTE, 1'b0};
            clk_cnt   <= '0;
            bit_cnt   <= '0;
        end else if (state != IDLE) begin
            if (!bit_end) begin
                clk_cnt <= clk_cnt + BW'(1);
            end else begin
                clk_cnt <= '0;
                if (bit_cnt != 4'd9) begin
                    bit_cnt <= bit_cnt + 4'd1;
                    shreg   <= {1'b1, shreg[9:1]};
                end else begin
                    bit_cnt <= '0;
                    if (state == DATA && last_byte) begin
                        shreg <= '1;
                    end else begin
                        word_idx <= nx_word;
                        byte_sel <= nx_sel;
                        shreg    <= {1'b1, nx_byte, 1'b0};
                    end
                end
            end
        end
    end

    assign tx_out = shreg[0];

endmodule

// File: tb/tb_uart_audio_packetizer.sv
// tb_uart_audio_packetizer: directed frames, byte scoreboard fed by stimulus,
// UART monitor decoding tx_out and popping expected bytes.
module tb_uart_audio_packetizer;

    localparam int NUM_CH = 4;
    localparam int SW     = 24;
    localparam int CPB    = 20;
    localparam int BYTE_C = 10 * CPB;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NUM_CH*SW-1:0] sample = '0;
    logic              sample_valid = 1'b0;
    logic              enable = 1'b0;
    logic [1:0]        mode = 2'd0;
    logic [1:0]        chan_sel = 2'd0;
    logic [3:0]        decim = 4'd0;
    logic              tx_out;
    logic              busy_out;
    logic              overflow_out;
    logic [15:0]       frame_count;

    int          cyc = 0;
    int          n_vec = 0;
    int          n_miss = 0;
    bit          rx_active = 1'b0;
    logic [7:0]  exp_q[$];

    uart_audio_packetizer #(
        .NUM_CH(NUM_CH), .SAMPLE_W(SW), .OUT_BYTES(2), .FIFO_DEPTH(4),
        .CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)
    ) dut (
        .clk_in(clk), .rst_n_in(rst_n), .sample_in(sample),
        .sample_valid_in(sample_valid), .enable_in(enable),
        .mode_in(mode), .chan_sel_in(chan_sel), .decim_in(decim),
        .tx_out(tx_out), .busy_out(busy_out),
        .overflow_out(overflow_out), .frame_count_out(frame_count)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // UART monitor: mid-bit sampling on the falling clock edge.
    initial begin : monitor
        int cnt;
        int b;
        logic [7:0] rb;
        logic [7:0] e;
        cnt = 0;
        rb  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rx_active = 1'b0;
            end else if (!rx_active) begin
                if (tx_out === 1'b0) begin
                    rx_active = 1'b1;
                    cnt = 0;
                end
            end else begin
                cnt++;
                if (cnt % CPB == CPB / 2) begin
                    b = cnt / CPB;
                    if (b >= 1 && b <= 8) rb[b-1] = tx_out;
                    if (b == 9) begin
                        rx_active = 1'b0;
                        chk("stop_bit", 32'(tx_out), 1);
                        if (exp_q.size() == 0) begin
                            n_vec++;
                            n_miss++;
                            $display("FAIL rx_byte: got %02h, none expected", rb);
                        end else begin
                            e = exp_q.pop_front();
                            chk("rx_byte", 32'(rb), 32'(e));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(output int t);
        sample_valid = 1'b1;
        t = cyc;
        tick(1);
        sample_valid = 1'b0;
    endtask

    task automatic exp_word(input logic [15:0] w);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
    endtask

    task automatic set_ch(input int c, input logic [23:0] v);
        sample[c*SW +: SW] = v;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        tick(3);
        rst_n = 1'b1;
        tick(4);
    endtask

    task automatic wait_done(input string nm, input int budget);
        int k;
        k = 0;
        while (k < budget && (busy_out || rx_active || exp_q.size() != 0)) begin
            tick(1);
            k++;
        end
        if (k >= budget) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s_drain: still busy after %0d cycles, want idle", nm, k);
        end
    endtask

    initial begin
        int t;
        int k;
        int lows;

        // reset state
        tick(3);
        chk("rst_tx", 32'(tx_out), 1);
        chk("rst_busy", 32'(busy_out), 0);
        chk("rst_ovf", 32'(overflow_out), 0);
        chk("rst_fc", 32'(frame_count), 0);
        rst_n = 1'b1;
        tick(4);

        // mode 0, channel 2
        enable = 1'b1;
        mode = 2'd0;
        chan_sel = 2'd2;
        decim = 4'd0;
        set_ch(0, 24'hAAAAAA);
        set_ch(1, 24'hBBBBBB);
        set_ch(2, 24'h123456);
        set_ch(3, 24'hCCCCCC);
        exp_q.push_back(8'hA5);
        exp_word(16'h1234);
        strobe(t);
        k = 0;
        while (tx_out !== 1'b0 && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("m0_start_cycle", 32'(cyc), 32'(t + 2));
        k = 0;
        while (busy_out && k < 5000) begin
            @(negedge clk);
            k++;
        end
        chk("m0_frame_len", 32'(cyc - (t + 2)), 32'(3 * BYTE_C));
        chk("m0_fc", 32'(frame_count), 1);
        tick(1);
        wait_done("m0", 2000);

        // mode 1, all channels
        do_reset();
        mode = 2'd1;
        set_ch(0, 24'h111111);
        set_ch(1, 24'h222222);
        set_ch(2, 24'h333333);
        set_ch(3, 24'h444444);
        exp_q.push_back(8'hA5);
        exp_word(16'h1111);
        exp_word(16'h2222);
        exp_word(16'h3333);
        exp_word(16'h4444);
        strobe(t);
        wait_done("m1", 12 * BYTE_C);
        chk("m1_fc", 32'(frame_count), 1);

        // mode 2 test pattern with decimation by 4
        do_reset();
        mode = 2'd2;
        decim = 4'd3;
        set_ch(0, 24'hDEADBE);
        exp_q.push_back(8'hA5);
        for (int i = 0; i < 4; i++) exp_word(16'(i));
        exp_q.push_back(8'hA5);
        for (int i = 1; i < 5; i++) exp_word(16'(i));
        for (int i = 0; i < 8; i++) begin
            strobe(t);
            tick(3);
        end
        chk("m2_fc_after_strobes", 32'(frame_count), 2);
        wait_done("m2", 24 * BYTE_C);
        chk("m2_fc", 32'(frame_count), 2);

        // overflow: 7 strobes, 10 cycles apart
        do_reset();
        mode = 2'd1;
        decim = 4'd0;
        for (int i = 0; i < 7; i++) begin
            for (int c = 0; c < NUM_CH; c++)
                set_ch(c, {8'(i + 1), 8'(c), 8'hEE});
            if (i < 5) begin
                exp_q.push_back(8'hA5);
                for (int c = 0; c < NUM_CH; c++)
                    exp_word({8'(i + 1), 8'(c)});
            end
            strobe(t);
            tick(9);
        end
        chk("ovf_flag", 32'(overflow_out), 1);
        chk("ovf_fc", 32'(frame_count), 5);
        wait_done("ovf", 50 * BYTE_C);
        chk("ovf_sticky", 32'(overflow_out), 1);
        chk("ovf_fc_end", 32'(frame_count), 5);

        // enable and mode change mid-frame
        mode = 2'd1;
        decim = 4'd2;
        for (int c = 0; c < NUM_CH; c++)
            set_ch(c, {8'h70 + 8'(c), 8'h0F, 8'h00});
        exp_q.push_back(8'hA5);
        for (int c = 0; c < NUM_CH; c++)
            exp_word({8'h70 + 8'(c), 8'h0F});
        strobe(t);
        tick(2 * BYTE_C + 50);
        enable = 1'b0;
        mode = 2'd0;
        chan_sel = 2'd1;
        set_ch(1, 24'h999999);
        for (int i = 0; i < 3; i++) begin
            strobe(t);
            tick(5);
        end
        chk("mid_fc_disabled", 32'(frame_count), 6);
        wait_done("mid", 12 * BYTE_C);
        chk("mid_fc_end", 32'(frame_count), 6);
        enable = 1'b1;
        set_ch(1, 24'hABCDEF);
        exp_q.push_back(8'hA5);
        exp_word(16'hABCD);
        strobe(t);
        wait_done("reenable", 5 * BYTE_C);
        chk("reenable_fc", 32'(frame_count), 7);

        // reset in the middle of a byte
        mode = 2'd1;
        decim = 4'd0;
        strobe(t);
        tick(BYTE_C + 3 * CPB + 7);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_tx", 32'(tx_out), 1);
        chk("midrst_busy", 32'(busy_out), 0);
        chk("midrst_ovf", 32'(overflow_out), 0);
        chk("midrst_fc", 32'(frame_count), 0);
        tick(3);
        rst_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 3 * BYTE_C; i++) begin
            @(negedge clk);
            if (tx_out !== 1'b1 || busy_out !== 1'b0) lows++;
        end
        chk("midrst_line_idle", 32'(lows), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/uart_audio_packetizer.md
# uart_audio_packetizer

Parametrised multi-channel audio-to-UART framer and serialiser for the beamforming datapath. It captures per-channel samples from the TDM receiver or delay-sum stage, applies decimation and a channel-selection mode, and buffers whole frames in a small FIFO. Each frame goes out as a sync-prefixed byte stream on an internal 8N1 UART transmitter. It supersedes the separate single- and dual-mic UART paths with one block covering any channel count.

## Interface
- NUM_CH, 4, channels carried on sample_in
- SAMPLE_W, 24, bits per channel sample (signed)
- OUT_BYTES, 2, bytes sent per channel word; word = top OUT_BYTES*8 bits of sample
- FIFO_DEPTH, 4, frames buffered (power of 2, ≥2)
- CLKS_PER_BIT, 109, clk_in cycles per UART bit (921 600 baud at 100 MHz)
- SYNC_BYTE, 8'hA5, header byte preceding every frame
- clk_in  input  1  system clock
- rst_n_in  input  1  asynchronous, active-low reset
- sample_in  input  NUM_CH*SAMPLE_W  packed samples, channel 0 in LSBs
- sample_valid_in  input  1  single-cycle strobe, sample_in valid
- enable_in  input  1  capture enable
- mode_in  input  2  0 single channel, 1 all channels, 2 test pattern, 3 treated as 1
- chan_sel_in  input  $clog2(NUM_CH)  channel for mode 0; values ≥NUM_CH select channel 0
- decim_in  input  4  accept one of every decim_in+1 strobes
- tx_out  output  1  UART serial line, idle high
- busy_out  output  1  high while FIFO non-empty or serialiser active
- overflow_out  output  1  sticky: a frame was dropped on FIFO full
- frame_count_out  output  16  frames accepted into FIFO, wraps at 65535→0

## Operation
- Reset (async assert, sync deassert internally): tx_out=1, busy_out=0, overflow_out=0, frame_count_out=0, FIFO empty, decimation counter 0, FSM IDLE.
- Decimation: counter cleared while enable_in=0. With enable_in=1, a strobe is accepted when counter==0; counter then increments each strobe, wrapping at decim_in. First strobe after enable rises is always accepted.
- Frame build (on accepted strobe, combinational from current inputs; mode_in/chan_sel_in sampled at that cycle only):
  - mode 0: 1 word, sample of chan_sel_in.
  - mode 1/3: NUM_CH words, channel 0 first.
  - mode 2: NUM_CH words, word k = (frame_count_out + k) mod 2^(OUT_BYTES*8); sample_in ignored.
  - Word count stored with frame in FIFO.
- FIFO full on accept: frame dropped, overflow_out←1 (held until reset), frame_count_out unchanged. Otherwise frame written, frame_count_out increments.
- Serialiser FSM: IDLE → SYNC (send SYNC_BYTE) → DATA (send words in order, each word MSB byte first) → IDLE after last byte; pop at IDLE→SYNC. Back-to-back frames: IDLE lasts exactly one cycle.
- Byte: start bit 0, 8 data bits LSB first, stop bit 1; each bit CLKS_PER_BIT cycles.
- enable_in falling mid-frame: frame in flight and buffered frames still transmit fully.
- Simultaneous pop and push on full FIFO: push succeeds (no overflow).

## Timing
- Accepted strobe at cycle t with FIFO empty, FSM IDLE: write at t+1 edge, pop at t+1, tx_out low from cycle t+2.
- Frame duration: (1 + words*OUT_BYTES)*10*CLKS_PER_BIT cycles, plus 1 IDLE cycle between frames.
- busy_out rises the cycle after the write, falls the cycle after the last stop bit of the final buffered frame.
- Strobes arriving while sample_valid_in held >1 cycle: each high cycle counts as a strobe (sources must pulse).

## Test plan
- Reset: drive rst_n_in=0 mid-byte -> tx_out=1 within same cycle, busy_out=0, overflow_out=0, frame_count_out=0; no partial byte resumes after release.
- Mode 0, NUM_CH=4, chan_sel_in=2, ch2=24'h12_34_56, decim_in=0 -> tx bytes A5,12,34, start bit at t+2, frame length 3*10*109 cycles, frame_count_out=1.
- Mode 1, samples ch0..3 = 0x111111,0x222222,0x333333,0x444444 -> bytes A5,11,11,22,22,33,33,44,44.
- Mode 2, decim_in=3, 8 strobes -> exactly 2 frames; first words 0000,0001,0002,0003, second 0001,0002,0003,0004.
- Overflow: mode 1, strobes every 10 cycles, 7 strobes -> first frame popped, 4 buffered, 2 dropped, overflow_out=1 sticky, frame_count_out=5; all 5 frames emitted intact.
- Mid-frame changes: toggle enable_in low and mode_in to 0 during DATA -> current frame completes unchanged; no new frames until enable_in high.
